// File: rtl/draw_card_if.sv
// VGA + image-ROM bus for the card renderer.
// master: vga_in/rgb_pixel in, vga_out/pixel_address out.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

interface draw_card_if #(
  parameter int AW = 16
);
  logic [`VGA_BUS_SIZE-1:0] vga_in;
  logic [`VGA_BUS_SIZE-1:0] vga_out;
  logic [11:0]              rgb_pixel;
  logic [AW-1:0]            pixel_address;

  modport master (
    input  vga_in,
    input  rgb_pixel,
    output vga_out,
    output pixel_address
  );

  modport slave (
    output vga_in,
    output rgb_pixel,
    input  vga_out,
    input  pixel_address
  );
endinterface

// File: rtl/draw_card.sv
// Card overlay on the VGA bus with frame-paced flip animation.
// Ports: pclk/rst, enable/x_pos/y_pos/flip in, busy/face_up out, bus (VGA+ROM).
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module draw_card #(
  parameter int          WIDTH       = 200,
  parameter int          HEIGHT      = 112,
  parameter int          ADDR_X_BITS = 8,
  parameter int          ADDR_Y_BITS = 8,
  parameter int          ROM_LAT     = 2,
  parameter int          STEP        = 4,
  parameter int          KEY_EN      = 1,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F,
  parameter logic [11:0] BACK_COLOR  = 12'h0AA
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         enable,
  input  logic [10:0]  x_pos,
  input  logic [10:0]  y_pos,
  input  logic         flip,
  output logic         busy,
  output logic         face_up,
  draw_card_if.master  bus
);

  localparam int VB = `VGA_BUS_SIZE;
  localparam int AW = ADDR_Y_BITS + ADDR_X_BITS;
  localparam logic [11:0] HALF = 12'(WIDTH / 2);
  localparam logic [11:0] W12  = 12'(WIDTH);
  localparam logic [11:0] H12  = 12'(HEIGHT);
  localparam logic [11:0] S12  = 12'(STEP);

  typedef enum logic [1:0] {
    IDLE, SHRINK, EXPAND
  } state_t;

  state_t state_q, state_d;
  logic [11:0] off_q, off_d;
  logic busy_q, busy_d;
  logic face_q, face_d;
  logic vblnk_q;
  logic en_s_q, en_s_d;
  logic [10:0] xs_q, xs_d, ys_q, ys_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [VB-1:0] vga_out_q, vga_out_d;

  logic [VB-1:0] vga_p_q [ROM_LAT];
  logic [VB-1:0] vga_p_d [ROM_LAT];
  logic          win_p_q [ROM_LAT];
  logic          win_p_d [ROM_LAT];
  logic          fu_p_q  [ROM_LAT];
  logic          fu_p_d  [ROM_LAT];

  logic tick, in_win;
  logic [11:0] h12, v12, xs12, ys12;
  logic [ADDR_X_BITS-1:0] dx;
  logic [ADDR_Y_BITS-1:0] dy;
  logic [VB-1:0] last;
  logic [11:0] rgb_sel;

  assign h12  = {1'b0, bus.vga_in[37:27]};
  assign v12  = {1'b0, bus.vga_in[26:16]};
  assign xs12 = {1'b0, xs_q};
  assign ys12 = {1'b0, ys_q};
  assign tick = bus.vga_in[12] & ~vblnk_q;

  // Shadow registers only move on the frame tick, so a frame never tears.
  always_comb begin
    en_s_d = en_s_q;
    xs_d   = xs_q;
    ys_d   = ys_q;
    if (tick) begin
      en_s_d = enable;
      xs_d   = x_pos;
      ys_d   = y_pos;
    end
  end

  assign in_win = en_s_q
               && (h12 >= xs12 + off_q)
               && (h12 <  xs12 + W12 - off_q)
               && (v12 >= ys12)
               && (v12 <  ys12 + H12);

  assign dx = ADDR_X_BITS'(h12 - xs12);
  assign dy = ADDR_Y_BITS'(v12 - ys12);

  always_comb begin
    addr_d = '0;
    if (in_win && face_q) addr_d = {dy, dx};
  end

  // Bus and window flag ride along until the ROM data arrives.
  always_comb begin
    vga_p_d[0] = bus.vga_in;
    win_p_d[0] = in_win;
    fu_p_d[0]  = face_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      vga_p_d[i] = vga_p_q[i-1];
      win_p_d[i] = win_p_q[i-1];
      fu_p_d[i]  = fu_p_q[i-1];
    end
  end

  assign last = vga_p_q[ROM_LAT-1];

  always_comb begin
    rgb_sel = last[11:0];
    if (win_p_q[ROM_LAT-1]) begin
      if (!fu_p_q[ROM_LAT-1])
        rgb_sel = BACK_COLOR;
      else if ((KEY_EN != 0) && (bus.rgb_pixel == KEY_COLOR))
        rgb_sel = last[11:0];
      else
        rgb_sel = bus.rgb_pixel;
    end
    vga_out_d = {last[VB-1:12], rgb_sel};
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    busy_d  = busy_q;
    face_d  = face_q;
    unique case (state_q)
      IDLE: begin
        if (flip) begin
          state_d = SHRINK;
          busy_d  = 1'b1;
        end
      end
      SHRINK: begin
        if (tick) begin
          if (off_q + S12 >= HALF) begin
            off_d   = HALF;
            face_d  = ~face_q;
            state_d = EXPAND;
          end else begin
            off_d = off_q + S12;
          end
        end
      end
      EXPAND: begin
        if (tick) begin
          if (off_q <= S12) begin
            off_d   = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            off_d = off_q - S12;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      off_q     <= '0;
      busy_q    <= 1'b0;
      face_q    <= 1'b0;
      vblnk_q   <= 1'b0;
      en_s_q    <= 1'b0;
      xs_q      <= '0;
      ys_q      <= '0;
      addr_q    <= '0;
      vga_out_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        vga_p_q[i] <= '0;
        win_p_q[i] <= 1'b0;
        fu_p_q[i]  <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      busy_q    <= busy_d;
      face_q    <= face_d;
      vblnk_q   <= bus.vga_in[12];
      en_s_q    <= en_s_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      addr_q    <= addr_d;
      vga_out_q <= vga_out_d;
      for (int i = 0; i < ROM_LAT; i++) begin
        vga_p_q[i] <= vga_p_d[i];
        win_p_q[i] <= win_p_d[i];
        fu_p_q[i]  <= fu_p_d[i];
      end
    end
  end

  assign busy              = busy_q;
  assign face_up           = face_q;
  assign bus.pixel_address = addr_q;
  assign bus.vga_out       = vga_out_q;

endmodule

// File: tb/tb_draw_card.sv
// Directed bench for draw_card: latency, window, flip, key, reset.
// dut1 uses defaults; dut2 uses STEP=100 and KEY_EN=0.
module tb_draw_card;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        flip1 = 1'b0;
  logic        flip2 = 1'b0;
  logic [10:0] x_pos = '0;
  logic [10:0] y_pos = '0;
  logic        busy1, busy2, fu1, fu2;
  logic [37:0] vin = '0;
  logic [11:0] rom = '0;
  int pass_n = 0;
  int tot_n = 0;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] ri;
    logic [11:0] rv;
    logic [15:0] a;
    logic [11:0] e1;
    logic [11:0] e2;
  } vec_t;

  vec_t vt [8];
  logic [37:0] seq [7];

  draw_card_if #(.AW(16)) bus1 ();
  draw_card_if #(.AW(16)) bus2 ();

  assign bus1.vga_in    = vin;
  assign bus2.vga_in    = vin;
  assign bus1.rgb_pixel = rom;
  assign bus2.rgb_pixel = rom;

  draw_card dut1 (
    .pclk(pclk), .rst(rst), .enable(enable),
    .x_pos(x_pos), .y_pos(y_pos), .flip(flip1),
    .busy(busy1), .face_up(fu1), .bus(bus1)
  );

  draw_card #(.STEP(100), .KEY_EN(0)) dut2 (
    .pclk(pclk), .rst(rst), .enable(enable),
    .x_pos(x_pos), .y_pos(y_pos), .flip(flip2),
    .busy(busy2), .face_up(fu2), .bus(bus2)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [37:0] act,
                     input logic [37:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic tick(input logic f1, input logic f2);
    vin   = {26'd1, 12'd0};
    flip1 = f1;
    flip2 = f2;
    step();
    flip1 = 1'b0;
    flip2 = 1'b0;
    vin   = '0;
    step();
  endtask

  task automatic check_px(input logic [10:0] h, input logic [10:0] v,
                          input logic [11:0] ri, input logic [11:0] rv,
                          input logic [15:0] a1, input logic [15:0] a2,
                          input logic [11:0] e1, input logic [11:0] e2);
    vin = {h, v, 4'b0000, ri};
    step();
    chk($sformatf("addr1(%0d,%0d)", h, v), bus1.pixel_address, a1);
    chk($sformatf("addr2(%0d,%0d)", h, v), bus2.pixel_address, a2);
    vin = '0;
    step();
    rom = rv;
    step();
    chk($sformatf("rgb1(%0d,%0d)", h, v), bus1.vga_out[11:0], e1);
    chk($sformatf("rgb2(%0d,%0d)", h, v), bus2.vga_out[11:0], e2);
    rom = '0;
  endtask

  initial begin
    vt[0] = '{11'd412, 11'd328, 12'h555, 12'h123, 16'h0000, 12'h123, 12'h123};
    vt[1] = '{11'd511, 11'd338, 12'h555, 12'h123, 16'h0A63, 12'h123, 12'h123};
    vt[2] = '{11'd411, 11'd328, 12'h555, 12'h123, 16'h0000, 12'h555, 12'h555};
    vt[3] = '{11'd612, 11'd328, 12'h555, 12'h123, 16'h0000, 12'h555, 12'h555};
    vt[4] = '{11'd611, 11'd439, 12'h555, 12'h123, 16'h6FC7, 12'h123, 12'h123};
    vt[5] = '{11'd611, 11'd440, 12'h555, 12'h123, 16'h0000, 12'h555, 12'h555};
    vt[6] = '{11'd500, 11'd400, 12'h555, 12'hF0F, 16'h4858, 12'h555, 12'hF0F};
    vt[7] = '{11'd450, 11'd330, 12'h777, 12'h000, 16'h0226, 12'h000, 12'h000};

    for (int c = 0; c < 7; c++) begin
      logic [3:0] fl;
      fl = (c < 4) ? 4'(4'b1000 >> c) : 4'b0000;
      seq[c] = {11'(100 + c), 11'(c), fl, 12'(12'h100 + c)};
    end

    // reset state with a busy input bus
    vin = '1;
    step();
    step();
    chk("rst_vga_out", bus1.vga_out, 38'd0);
    chk("rst_addr", bus1.pixel_address, 16'd0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_face", fu1, 1'b0);
    rst = 1'b0;
    vin = '0;
    enable = 1'b1;
    x_pos = 11'd412;
    y_pos = 11'd328;
    step();

    // every field delayed by exactly 3 cycles
    for (int c = 0; c < 7; c++) begin
      vin = seq[c];
      step();
      if (c >= 2) chk($sformatf("latency_c%0d", c), bus1.vga_out, seq[c-2]);
    end
    vin = '0;
    step();

    check_px(11'd412, 11'd328, 12'h555, 12'h123, 16'h0, 16'h0, 12'h0AA, 12'h0AA);

    // flip coinciding with a tick: no increment yet
    tick(1'b1, 1'b1);
    chk("flip_busy1", busy1, 1'b1);
    chk("flip_busy2", busy2, 1'b1);
    chk("flip_face1", fu1, 1'b0);

    for (int k = 1; k <= 50; k++) begin
      tick(k == 5, 1'b0);
      if (k == 7) begin
        flip1 = 1'b1;
        step();
        flip1 = 1'b0;
      end
      chk($sformatf("busy1_t%0d", k), busy1, k < 50);
      chk($sformatf("face1_t%0d", k), fu1, k >= 25);
      if (k == 1) begin
        chk("face2_t1", fu2, 1'b1);
        chk("busy2_t1", busy2, 1'b1);
      end
      if (k == 2) chk("busy2_t2", busy2, 1'b0);
      if (k == 10) begin
        check_px(11'd451, 11'd328, 12'h555, 12'h123, 16'h0, 16'h0027, 12'h555, 12'h123);
        check_px(11'd452, 11'd328, 12'h555, 12'h123, 16'h0, 16'h0028, 12'h0AA, 12'h123);
        check_px(11'd571, 11'd328, 12'h555, 12'h123, 16'h0, 16'h009F, 12'h0AA, 12'h123);
        check_px(11'd572, 11'd328, 12'h555, 12'h123, 16'h0, 16'h00A0, 12'h555, 12'h123);
      end
    end

    // both face up and idle
    for (int i = 0; i < 8; i++)
      check_px(vt[i].h, vt[i].v, vt[i].ri, vt[i].rv,
               vt[i].a, vt[i].a, vt[i].e1, vt[i].e2);

    // mid-frame position change waits for the next tick
    x_pos = 11'd0;
    check_px(11'd412, 11'd328, 12'h555, 12'h123, 16'h0, 16'h0, 12'h123, 12'h123);
    check_px(11'd0, 11'd328, 12'h555, 12'h123, 16'h0, 16'h0, 12'h555, 12'h555);
    tick(1'b0, 1'b0);
    check_px(11'd0, 11'd328, 12'h555, 12'h123, 16'h0, 16'h0, 12'h123, 12'h123);
    check_px(11'd412, 11'd328, 12'h555, 12'h123, 16'h0, 16'h0, 12'h555, 12'h555);
    check_px(11'd199, 11'd329, 12'h555, 12'h123, 16'h01C7, 16'h01C7, 12'h123, 12'h123);

    // disabled card is a pure pass-through
    enable = 1'b0;
    tick(1'b0, 1'b0);
    check_px(11'd10, 11'd330, 12'h555, 12'h123, 16'h0, 16'h0, 12'h555, 12'h555);

    // reset in the middle of an animation (off = 60)
    enable = 1'b1;
    x_pos = 11'd412;
    tick(1'b0, 1'b0);
    flip1 = 1'b1;
    step();
    flip1 = 1'b0;
    for (int k = 0; k < 15; k++) tick(1'b0, 1'b0);
    chk("pre_rst_busy", busy1, 1'b1);
    vin = {11'd100, 11'd5, 4'b1111, 12'h321};
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vga_out", bus1.vga_out, 38'd0);
    chk("arst_addr", bus1.pixel_address, 16'd0);
    chk("arst_busy", busy1, 1'b0);
    chk("arst_face1", fu1, 1'b0);
    chk("arst_face2", fu2, 1'b0);
    vin = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", busy1, 1'b0);
    chk("post_rst_face", fu1, 1'b0);
    tick(1'b0, 1'b0);
    check_px(11'd412, 11'd328, 12'h555, 12'h123, 16'h0, 16'h0, 12'h0AA, 12'h0AA);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/draw_card.md
Name: draw_card

Overview:
Parametrised card renderer for the Memory Game VGA chain. Overlays a WIDTH x HEIGHT card at a runtime position onto the VGA bus. A face-up card is pixels from an external image ROM; a face-down card is a solid back colour. On a flip request it runs a frame-paced flip animation: the visible width shrinks symmetrically to zero, the face swaps, then the width expands back. Face-up pixels matching an optional colour key are transparent.

Parameters:
WIDTH, 200, card width in pixels; must be even and <= 2^ADDR_X_BITS.
HEIGHT, 112, card height in pixels; must be <= 2^ADDR_Y_BITS.
ADDR_X_BITS, 8, ROM column address width.
ADDR_Y_BITS, 8, ROM row address width.
ROM_LAT, 2, cycles from vga_in sample to matching rgb_pixel; must be >= 2.
STEP, 4, pixels removed from or added to each side per frame during animation; must be >= 1.
KEY_EN, 1, enables the colour key on face-up pixels.
KEY_COLOR, 12'hF_0_F, transparent colour.
BACK_COLOR, 12'h0_A_A, face-down fill colour.

Ports:
pclk  in  1  pixel clock; all logic is clocked on its rising edge.
rst  in  1  asynchronous, active-high reset.
enable  in  1  draw request; sampled at each frame tick.
x_pos  in  11  card left edge; sampled at each frame tick.
y_pos  in  11  card top edge; sampled at each frame tick.
flip  in  1  single-cycle flip request.
busy  out  1  high while an animation is running.
face_up  out  1  current face; 1 = image, 0 = back.
rgb_pixel  in  12  ROM data.
pixel_address  out  ADDR_Y_BITS+ADDR_X_BITS  ROM address, row bits in the upper field.
vga_in  in  `VGA_BUS_SIZE  VGA bus: hcount, vcount, hs, vs, hblnk, vblnk, rgb.
vga_out  out  `VGA_BUS_SIZE  VGA bus with the card overlaid.

Behaviour:
- Reset is asynchronous and active-high; it acts immediately, including mid-animation. While reset is asserted:
  - vga_out fields, pixel_address, busy and face_up are all 0.
  - The FSM is in IDLE; off = 0.
  - Shadow registers (en_s, xs, ys) and the vblnk edge register are 0.
- Frame tick: a single-cycle pulse on the vblnk_in 0->1 edge, detected with one register.
  - At the tick, en_s, xs and ys load enable, x_pos and y_pos.
  - The shadow values are constant for the whole frame, so no tearing.
- Window: 12-bit unsigned compares, so no wrap.
  - xs+off <= hcount < xs+WIDTH-off
  - ys <= vcount < ys+HEIGHT
  - en_s = 1
  - When off = WIDTH/2 the window is empty.
- Address: registered at cycle N+1 for the vga_in sampled at cycle N.
  - Inside the window with face_up = 1: address = {vcount-ys, hcount-xs}, truncated to field widths.
  - The image is cropped by the animation, not scaled.
  - Otherwise the address is 0.
- Pipeline: every vga_in field, plus a window/face flag computed at N, is delayed so that it aligns with rgb_pixel at cycle N+ROM_LAT. vga_out is registered at N+ROM_LAT+1.
  - Total latency is ROM_LAT+1 for every field, sync and blank included.
  - hcount, vcount, hs, vs, hblnk and vblnk pass through unchanged.
- rgb_out select:
  - Outside the window: delayed rgb_in.
  - Face down: BACK_COLOR.
  - Face up, KEY_EN = 1 and rgb_pixel == KEY_COLOR: delayed rgb_in.
  - Otherwise: rgb_pixel.
- FSM states: IDLE, SHRINK, EXPAND. Transitions are evaluated on the frame tick unless stated.
  - IDLE: flip = 1 -> SHRINK, busy = 1. off is unchanged in that cycle, even if the flip coincides with a tick.
  - SHRINK: on a tick, off <= off+STEP.
    - If off+STEP >= WIDTH/2: off <= WIDTH/2 (clamped), face_up toggles, go to EXPAND.
  - EXPAND: on a tick, if off <= STEP then off <= 0, go to IDLE, busy <= 0 in that cycle; else off <= off-STEP.
  - flip while busy is ignored; there is no queueing.
- enable is independent of the animation: the animation advances even while en_s = 0.
- busy and face_up are registered outputs.

Test Plan:
- Static face up (after one flip, STEP = WIDTH/2): x_pos = 412, y_pos = 328, ROM returns 12'h123 -> pixel (412,328) is 12'h123 exactly ROM_LAT+1 cycles after input; address 0x0000 at (412,328), 0x0A63 at (511,338); (411,328) and (612,328) pass rgb_in.
- Latency alignment: toggle hs_in, vs_in, hblnk_in and vblnk_in on distinct cycles -> each appears on vga_out exactly 3 cycles later (ROM_LAT = 2), with no skew between fields.
- Flip sequence (WIDTH = 200, STEP = 4): pulse flip -> busy = 1; off = 4, 8, ..., 96, then 100 with face_up toggling on the 25th tick; off reaches 0 and busy = 0 on the 50th tick. On the 10th tick off = 40, so the window covers hcount 452..571.
- Colour key: face up, ROM returns 12'hF0F, rgb_in = 12'h555 -> output 12'h555. With KEY_EN = 0 -> output 12'hF0F.
- Boundaries:
  - x_pos changed mid-frame -> no effect until the next vblnk rise.
  - Second flip during SHRINK -> ignored, total still 50 ticks.
  - flip coinciding with a tick -> first increment on the following tick.
  - enable = 0 -> pure pass-through, address 0.
- Reset mid-animation: assert rst at off = 60 -> all outputs 0 immediately (asynchronously); after release, state IDLE, face_up = 0, off = 0, next frame draws the back colour 12'h0AA if enabled.
